// File: rtl/clz_32_unit.sv
// Registered count-leading-zeros for 32-bit words: nibble encoders merged by a
// binary priority tree, with the result registered one cycle after in_valid.
module clz_32_unit #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in,
    output logic                 out_valid,
    output logic [CNT_WIDTH-1:0] out,
    output logic                 all_zero
);

    logic [1:0] cnt4  [8];
    logic       zero4 [8];
    logic [2:0] cnt8  [4];
    logic       zero8 [4];
    logic [3:0] cnt16 [2];
    logic       zero16[2];
    logic [4:0] cnt32;
    logic       zero32;
    logic [CNT_WIDTH-1:0] cnt_next;

    // Nibble i covers in[4i+3:4i]; an all-zero nibble reports 3 with its zero flag set.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            zero4[i] = (in[4*i +: 4] == 4'b0000);
            casez (in[4*i +: 4])
                4'b1???: cnt4[i] = 2'd0;
                4'b01??: cnt4[i] = 2'd1;
                4'b001?: cnt4[i] = 2'd2;
                default: cnt4[i] = 2'd3;
            endcase
        end
    end

    // Each merge takes the upper half's count unless the upper half is empty,
    // in which case the count is half-width plus the lower half's count.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            zero8[i] = zero4[2*i+1] & zero4[2*i];
            cnt8[i]  = zero4[2*i+1] ? {1'b1, cnt4[2*i]} : {1'b0, cnt4[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            zero16[i] = zero8[2*i+1] & zero8[2*i];
            cnt16[i]  = zero8[2*i+1] ? {1'b1, cnt8[2*i]} : {1'b0, cnt8[2*i+1]};
        end
        zero32   = zero16[1] & zero16[0];
        cnt32    = zero16[1] ? {1'b1, cnt16[0]} : {1'b0, cnt16[1]};
        cnt_next = zero32 ? CNT_WIDTH'(WIDTH) : {1'b0, cnt32};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            all_zero  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out      <= cnt_next;
                all_zero <= zero32;
            end
        end
    end

endmodule

// File: tb/tb_clz_32_unit.sv
// Directed and random checks for clz_32_unit: reset, boundaries, adder usage,
// walking one, valid gaps with async reset, and a random stream.
module tb_clz_32_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] din;
    logic        out_valid;
    logic [5:0]  out;
    logic        all_zero;

    int vectors = 0;
    int miscompares = 0;

    clz_32_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in       (din),
        .out_valid(out_valid),
        .out      (out),
        .all_zero (all_zero)
    );

    always #5 clk = ~clk;

    // Drive at the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [31:0] w);
        @(negedge clk);
        in_valid = v;
        din      = w;
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_clz(input logic [31:0] w);
        for (int b = 31; b >= 0; b--)
            if (w[b]) return 31 - b;
        return 32;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; din = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (out !== 6'd0) begin miscompares++; $display("FAIL reset_out got %0d want 0", out); end
        vectors++; if (all_zero !== 1'b0) begin miscompares++; $display("FAIL reset_az got %b want 0", all_zero); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b1 || out !== 6'd0 || all_zero !== 1'b0) begin
            miscompares++; $display("FAIL reset_first got v=%b out=%0d az=%b want v=1 out=0 az=0", out_valid, out, all_zero);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] w[3] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000};
        logic [5:0]  e[3] = '{6'd0, 6'd31, 6'd32};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, w[i]);
            vectors++; if (out_valid !== 1'b1 || out !== e[i] || all_zero !== (i == 2)) begin
                miscompares++; $display("FAIL boundary[%0d] got v=%b out=%0d az=%b want v=1 out=%0d az=%b", i, out_valid, out, all_zero, e[i], (i == 2));
            end
        end
    endtask

    task automatic test_adder_usage();
        logic [31:0] w[3] = '{{8'h00, 24'h80_0000}, {8'h00, 24'h00_0001}, {8'h00, 24'h00_0000}};
        logic [5:0]  e[3] = '{6'd8, 6'd31, 6'd32};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, w[i]);
            vectors++; if (out_valid !== 1'b1 || out !== e[i] || all_zero !== (i == 2)) begin
                miscompares++; $display("FAIL adder[%0d] got v=%b out=%0d az=%b want v=1 out=%0d az=%b", i, out_valid, out, all_zero, e[i], (i == 2));
            end
        end
    endtask

    task automatic test_walking_one();
        logic [31:0] one, mask, w;
        for (int k = 0; k < 32; k++) begin
            one  = 32'h1 << k;
            mask = one - 32'h1;
            for (int r = 0; r < 2; r++) begin
                w = (r == 0) ? one : (one | ($urandom() & mask));
                step(1'b1, w);
                vectors++; if (out_valid !== 1'b1 || out !== 6'(31 - k) || all_zero !== 1'b0) begin
                    miscompares++; $display("FAIL walk k=%0d w=%h got v=%b out=%0d az=%b want v=1 out=%0d az=0", k, w, out_valid, out, all_zero, 31 - k);
                end
            end
        end
    endtask

    task automatic test_valid_gaps();
        step(1'b1, 32'h0000_F000);
        vectors++; if (out_valid !== 1'b1 || out !== 6'd16) begin
            miscompares++; $display("FAIL gap_accept got v=%b out=%0d want v=1 out=16", out_valid, out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i == 1) ? 32'hxxxx_xxxx : 32'h0);
            vectors++; if (out_valid !== 1'b0 || out !== 6'd16 || all_zero !== 1'b0) begin
                miscompares++; $display("FAIL gap[%0d] got v=%b out=%0d az=%b want v=0 out=16 az=0", i, out_valid, out, all_zero);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (out !== 6'd0 || out_valid !== 1'b0 || all_zero !== 1'b0) begin
            miscompares++; $display("FAIL gap_async_reset got v=%b out=%0d az=%b want 0/0/0", out_valid, out, all_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0);
        vectors++; if (out_valid !== 1'b0 || out !== 6'd0) begin
            miscompares++; $display("FAIL gap_after_reset got v=%b out=%0d want v=0 out=0", out_valid, out);
        end
    endtask

    task automatic test_random();
        int          exp_out = 0;
        logic        v;
        logic [31:0] w;
        for (int n = 0; n < 10000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            w = $urandom() >> $urandom_range(0, 32);
            step(v, w);
            if (v) exp_out = ref_clz(w);
            vectors++; if (out_valid !== v) begin
                miscompares++; $display("FAIL rand_valid n=%0d got %b want %b", n, out_valid, v);
            end
            vectors++; if (out !== 6'(exp_out)) begin
                miscompares++; $display("FAIL rand_out n=%0d w=%h got %0d want %0d", n, w, out, exp_out);
            end
            vectors++; if (all_zero !== (out == 6'd32)) begin
                miscompares++; $display("FAIL rand_az n=%0d got az=%b with out=%0d", n, all_zero, out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_boundaries();
        test_adder_usage();
        test_walking_one();
        test_valid_gaps();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
